// File: rtl/mmio_rsp_queue.sv
// MMIO read-response stage between the AFU register file and CCI-P TX c2.
// Tracks outstanding read tids, buffers responses, and flags protocol violations.
module mmio_rsp_queue #(
  parameter int DEPTH   = 8,
  parameter int TID_W   = 9,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 512
) (
  input  logic                       pClk,
  input  logic                       pck_cp2af_softReset_n,
  input  logic                       req_valid,
  input  logic [TID_W-1:0]           req_tid,
  input  logic                       rsp_in_valid,
  input  logic [TID_W-1:0]           rsp_in_tid,
  input  logic [DATA_W-1:0]          rsp_in_data,
  input  logic                       c2_hold,
  input  logic                       err_clr,
  output logic                       rsp_out_valid,
  output logic [TID_W-1:0]           rsp_out_tid,
  output logic [DATA_W-1:0]          rsp_out_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic [31:0]                rsp_count,
  output logic                       err_overflow,
  output logic                       err_tid_mismatch,
  output logic                       err_timeout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam int RSP_W = TID_W + DATA_W;

  localparam logic [AW:0]      PTR_ONE  = 1;
  localparam logic [AGE_W-1:0] AGE_ONE  = 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

  logic [TID_W-1:0] reqMem [DEPTH];
  logic [AW:0]      reqWr;
  logic [AW:0]      reqRd;
  logic             reqEmpty;
  logic             reqFull;
  logic             reqPush;
  logic             reqPop;
  logic             reqDrop;

  logic [RSP_W-1:0] rspMem [DEPTH];
  logic [AW:0]      rspWr;
  logic [AW:0]      rspRd;
  logic             rspEmpty;
  logic             rspFull;
  logic             rspPush;
  logic             rspPop;
  logic             rspDrop;

  logic             tidBad;
  logic [AGE_W-1:0] age;
  logic             ageHit;

  // Extra MSB on each pointer separates full from empty when the index bits match.
  assign reqEmpty = (reqWr == reqRd);
  assign reqFull  = (reqWr[AW] != reqRd[AW]) && (reqWr[AW-1:0] == reqRd[AW-1:0]);
  assign reqPop   = rsp_in_valid && !reqEmpty;
  assign reqPush  = req_valid && (!reqFull || reqPop);
  assign reqDrop  = req_valid && reqFull && !reqPop;

  assign rspEmpty = (rspWr == rspRd);
  assign rspFull  = (rspWr[AW] != rspRd[AW]) && (rspWr[AW-1:0] == rspRd[AW-1:0]);
  assign rspPop   = !rspEmpty && !c2_hold;
  assign rspPush  = rsp_in_valid && (!rspFull || rspPop);
  assign rspDrop  = rsp_in_valid && rspFull && !rspPop;

  // Head is read before this cycle's push lands, so a same-cycle request never matches.
  assign tidBad = rsp_in_valid && (reqEmpty || (reqMem[reqRd[AW-1:0]] != rsp_in_tid));

  assign ageHit = !reqEmpty && !reqPop && (age == AGE_LAST);

  assign outstanding = OCC_W'(reqWr - reqRd);

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset_n && reqPush) begin
      reqMem[reqWr[AW-1:0]] <= req_tid;
    end
    if (pck_cp2af_softReset_n && rspPush) begin
      rspMem[rspWr[AW-1:0]] <= {rsp_in_tid, rsp_in_data};
    end
  end

  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      reqWr            <= '0;
      reqRd            <= '0;
      rspWr            <= '0;
      rspRd            <= '0;
      age              <= '0;
      rsp_out_valid    <= 1'b0;
      rsp_out_tid      <= '0;
      rsp_out_data     <= '0;
      rsp_count        <= '0;
      err_overflow     <= 1'b0;
      err_tid_mismatch <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      if (reqPush) reqWr <= reqWr + PTR_ONE;
      if (reqPop)  reqRd <= reqRd + PTR_ONE;
      if (rspPush) rspWr <= rspWr + PTR_ONE;
      if (rspPop)  rspRd <= rspRd + PTR_ONE;

      if (reqPop || reqEmpty) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + AGE_ONE;
      end

      rsp_out_valid <= rspPop;
      if (rspPop) begin
        {rsp_out_tid, rsp_out_data} <= rspMem[rspRd[AW-1:0]];
        rsp_count                   <= rsp_count + 32'd1;
      end

      // A new error event in the same cycle as err_clr keeps the flag set.
      err_overflow     <= reqDrop || rspDrop || (err_overflow && !err_clr);
      err_tid_mismatch <= tidBad || (err_tid_mismatch && !err_clr);
      err_timeout      <= ageHit || (err_timeout && !err_clr);
    end
  end

endmodule

// File: tb/tb_mmio_rsp_queue.sv
// Directed bench for mmio_rsp_queue: expected responses go into a scoreboard
// queue and an independent monitor checks every rsp_out_valid pulse against it.
module tb_mmio_rsp_queue;

  localparam int DEPTH   = 8;
  localparam int TID_W   = 9;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 512;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic                       pClk = 1'b0;
  logic                       pck_cp2af_softReset_n;
  logic                       req_valid;
  logic [TID_W-1:0]           req_tid;
  logic                       rsp_in_valid;
  logic [TID_W-1:0]           rsp_in_tid;
  logic [DATA_W-1:0]          rsp_in_data;
  logic                       c2_hold;
  logic                       err_clr;
  logic                       rsp_out_valid;
  logic [TID_W-1:0]           rsp_out_tid;
  logic [DATA_W-1:0]          rsp_out_data;
  logic [$clog2(DEPTH+1)-1:0] outstanding;
  logic [31:0]                rsp_count;
  logic                       err_overflow;
  logic                       err_tid_mismatch;
  logic                       err_timeout;

  int   vecs = 0;
  int   fails = 0;
  int   expCount = 0;
  rsp_t expQ[$];

  mmio_rsp_queue #(.DEPTH(DEPTH), .TID_W(TID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (pck_cp2af_softReset_n),
    .req_valid             (req_valid),
    .req_tid               (req_tid),
    .rsp_in_valid          (rsp_in_valid),
    .rsp_in_tid            (rsp_in_tid),
    .rsp_in_data           (rsp_in_data),
    .c2_hold               (c2_hold),
    .err_clr               (err_clr),
    .rsp_out_valid         (rsp_out_valid),
    .rsp_out_tid           (rsp_out_tid),
    .rsp_out_data          (rsp_out_data),
    .outstanding           (outstanding),
    .rsp_count             (rsp_count),
    .err_overflow          (err_overflow),
    .err_tid_mismatch      (err_tid_mismatch),
    .err_timeout           (err_timeout)
  );

  always #5 pClk = ~pClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic sendReq(input logic [TID_W-1:0] tid);
    req_valid = 1'b1;
    req_tid   = tid;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic sendRsp(input logic [TID_W-1:0] tid, input logic [DATA_W-1:0] data,
                         input bit expectOut);
    rsp_in_valid = 1'b1;
    rsp_in_tid   = tid;
    rsp_in_data  = data;
    if (expectOut) begin
      expQ.push_back('{tid: tid, data: data});
      expCount++;
    end
    tick();
    rsp_in_valid = 1'b0;
  endtask

  task automatic clearErrs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge pClk);
      if (rsp_out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          vecs++;
          fails++;
          $display("FAIL unexpected_pulse: got tid 0x%0h, expected no pulse", rsp_out_tid);
        end else begin
          e = expQ.pop_front();
          chk("out_tid", 64'(rsp_out_tid), 64'(e.tid));
          chk("out_data", rsp_out_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    pck_cp2af_softReset_n = 1'b0;
    req_valid    = 1'b0;
    req_tid      = '0;
    rsp_in_valid = 1'b0;
    rsp_in_tid   = '0;
    rsp_in_data  = '0;
    c2_hold      = 1'b0;
    err_clr      = 1'b0;
    repeat (3) tick();

    chk("rst_valid", 64'(rsp_out_valid), 0);
    chk("rst_tid", 64'(rsp_out_tid), 0);
    chk("rst_data", rsp_out_data, 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_count", 64'(rsp_count), 0);
    chk("rst_errs", 64'({err_overflow, err_tid_mismatch, err_timeout}), 0);
    pck_cp2af_softReset_n = 1'b1;
    tick();

    // Single read with 2-cycle response latency.
    sendReq(9'h05);
    chk("single_outstanding1", 64'(outstanding), 1);
    tick();
    tick();
    sendRsp(9'h05, 64'h0000_0000_DEAD_BEEF, 1'b1);
    chk("single_lat1_valid", 64'(rsp_out_valid), 0);
    chk("single_outstanding0", 64'(outstanding), 0);
    tick();
    chk("single_lat2_valid", 64'(rsp_out_valid), 1);
    tick();
    chk("single_pulse_end", 64'(rsp_out_valid), 0);
    chk("single_tid_hold", 64'(rsp_out_tid), 64'h05);
    chk("single_count", 64'(rsp_count), 1);
    chk("single_errs", 64'({err_overflow, err_tid_mismatch, err_timeout}), 0);

    // Throttle, fill both FIFOs, overflow the response FIFO, then drain.
    c2_hold = 1'b1;
    for (int i = 0; i < 8; i++) sendReq(9'(i));
    chk("fill_outstanding", 64'(outstanding), 8);
    for (int i = 0; i < 8; i++) sendRsp(9'(i), 64'hC0DE_0000_0000_0000 | 64'(i), 1'b1);
    chk("fill_no_ovf", 64'(err_overflow), 0);
    chk("fill_no_mismatch", 64'(err_tid_mismatch), 0);
    sendReq(9'h08);
    sendRsp(9'h08, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    chk("fill_ovf", 64'(err_overflow), 1);
    chk("fill_ovf_tid_ok", 64'(err_tid_mismatch), 0);
    clearErrs();
    chk("fill_ovf_cleared", 64'(err_overflow), 0);
    c2_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_b2b_valid", 64'(rsp_out_valid), 1);
    end
    tick();
    chk("drain_done_valid", 64'(rsp_out_valid), 0);
    chk("drain_count", 64'(rsp_count), 64'(expCount));

    // Tid mismatch against head, and response with nothing outstanding.
    sendReq(9'h10);
    sendRsp(9'h11, 64'h1111_1111_1111_1111, 1'b1);
    chk("mismatch_set", 64'(err_tid_mismatch), 1);
    tick();
    clearErrs();
    chk("mismatch_cleared", 64'(err_tid_mismatch), 0);
    sendRsp(9'h22, 64'h2222_2222_2222_2222, 1'b1);
    chk("mismatch_empty", 64'(err_tid_mismatch), 1);
    clearErrs();

    // Zero-cycle response: request not yet visible to the check.
    req_valid = 1'b1;
    req_tid   = 9'h33;
    sendRsp(9'h33, 64'h3333_0000_0000_0001, 1'b1);
    req_valid = 1'b0;
    chk("zero_cycle_mismatch", 64'(err_tid_mismatch), 1);
    chk("zero_cycle_outstanding", 64'(outstanding), 1);
    clearErrs();
    sendRsp(9'h33, 64'h3333_0000_0000_0002, 1'b1);
    chk("zero_cycle_match", 64'(err_tid_mismatch), 0);
    chk("zero_cycle_drained", 64'(outstanding), 0);

    // Clear and a new mismatch in the same cycle: set wins.
    err_clr = 1'b1;
    sendRsp(9'h77, 64'h7777_7777_7777_7777, 1'b1);
    err_clr = 1'b0;
    chk("set_wins", 64'(err_tid_mismatch), 1);
    clearErrs();
    repeat (3) tick();

    // Timeout: flag rises exactly when age reaches TIMEOUT.
    sendReq(9'h40);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_511", 64'(err_timeout), 0);
    tick();
    chk("timeout_512", 64'(err_timeout), 1);
    clearErrs();
    chk("timeout_cleared", 64'(err_timeout), 0);
    repeat (5) tick();
    chk("timeout_stays_clear", 64'(err_timeout), 0);
    sendRsp(9'h40, 64'h4040_4040_4040_4040, 1'b1);
    chk("timeout_after_rsp", 64'(err_timeout), 0);
    chk("timeout_rsp_match", 64'(err_tid_mismatch), 0);
    repeat (3) tick();

    // Simultaneous push and pop on both full FIFOs.
    c2_hold = 1'b1;
    for (int i = 0; i < 8; i++) sendReq(9'(9'h50 + i));
    for (int i = 0; i < 8; i++) sendRsp(9'(9'h50 + i), 64'h5050_0000_0000_0000 | 64'(i), 1'b1);
    for (int i = 0; i < 8; i++) sendReq(9'(9'h60 + i));
    chk("simul_req_full", 64'(outstanding), 8);
    c2_hold   = 1'b0;
    req_valid = 1'b1;
    req_tid   = 9'h68;
    sendRsp(9'h60, 64'h6060_6060_6060_6060, 1'b1);
    req_valid = 1'b0;
    chk("simul_no_ovf", 64'(err_overflow), 0);
    chk("simul_no_mismatch", 64'(err_tid_mismatch), 0);
    chk("simul_outstanding", 64'(outstanding), 8);
    repeat (11) tick();
    chk("simul_count", 64'(rsp_count), 64'(expCount));
    chk("simul_sb_empty", 64'(expQ.size()), 0);

    // Reset mid-burst with 4 responses buffered: they must vanish.
    c2_hold = 1'b1;
    for (int i = 1; i <= 4; i++) sendRsp(9'(9'h60 + i), 64'h6161_0000_0000_0000 | 64'(i), 1'b0);
    pck_cp2af_softReset_n = 1'b0;
    c2_hold   = 1'b0;
    req_valid = 1'b1;
    req_tid   = 9'h1FF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(rsp_out_valid), 0);
    chk("mid_rst_tid", 64'(rsp_out_tid), 0);
    chk("mid_rst_data", rsp_out_data, 0);
    chk("mid_rst_outstanding", 64'(outstanding), 0);
    chk("mid_rst_count", 64'(rsp_count), 0);
    chk("mid_rst_errs", 64'({err_overflow, err_tid_mismatch, err_timeout}), 0);
    pck_cp2af_softReset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_valid", 64'(rsp_out_valid), 0);
    chk("post_rst_count", 64'(rsp_count), 0);
    chk("post_rst_outstanding", 64'(outstanding), 0);
    chk("final_sb_empty", 64'(expQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/mmio_rsp_queue.md
# mmio_rsp_queue

MMIO read-response stage placed directly downstream of the AFU MMIO register file and upstream of CCI-P TX channel 2. It tracks outstanding MMIO read requests by tid and buffers register-file read responses in a FIFO. It drains the responses onto c2 one per cycle and checks CCI-P MMIO rules: in-order tid match, no overflow, and response within a timeout. The checks report through sticky error flags, so stress tests can run MMIO read/write traffic through it and detect protocol violations.

## Interface
Parameters:
- DEPTH, 8: entries in both the request-tid FIFO and the response FIFO; power of two, 2..64.
- TID_W, 9: MMIO transaction-id width (CCI-P tid).
- DATA_W, 64: response data width.
- TIMEOUT, 512: maximum number of cycles a request may remain unanswered.

Ports:
- pClk  in  1  sole clock; all logic rising-edge.
- pck_cp2af_softReset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  an MMIO read request is observed this cycle (from RX c0 mmioRdValid).
- req_tid  in  TID_W  tid of that request.
- rsp_in_valid  in  1  the register file presents a read response.
- rsp_in_tid  in  TID_W  tid of the response.
- rsp_in_data  in  DATA_W  response data.
- c2_hold  in  1  throttle; while high, no response is issued.
- err_clr  in  1  clears all sticky error flags.
- rsp_out_valid  out  1  drives c2 mmioRdValid; single-cycle pulse per response.
- rsp_out_tid  out  TID_W  drives c2 hdr.tid.
- rsp_out_data  out  DATA_W  drives c2 data.
- outstanding  out  $clog2(DEPTH+1)  current occupancy of the request FIFO.
- rsp_count  out  32  number of responses issued; wraps at 2^32.
- err_overflow  out  1  sticky; a request or response was dropped because its FIFO was full.
- err_tid_mismatch  out  1  sticky; a response tid did not match the oldest outstanding request, or no request was outstanding.
- err_timeout  out  1  sticky; the oldest request went unanswered for TIMEOUT cycles.

## Operation
Request FIFO:
- `req_valid` pushes `req_tid`.
- Every `rsp_in_valid` pops the head, whether or not the tid matches. Popping an empty FIFO does nothing.
- A push and a pop in the same cycle both take effect; occupancy is unchanged.

Tid check:
- On `rsp_in_valid`, `rsp_in_tid` is compared with the request-FIFO head.
- If they differ, or the FIFO is empty, `err_tid_mismatch` is set.
- A request pushed in the same cycle is not visible to this comparison; a zero-cycle response therefore counts as a mismatch.

Response FIFO:
- `rsp_in_valid` pushes `{rsp_in_tid, rsp_in_data}`, whatever the result of the tid check.

Drain:
- When the response FIFO is non-empty and `c2_hold` is 0, the head is popped into the output registers and `rsp_out_valid` is high for one cycle.
- At most one response is issued per cycle.
- `rsp_out_tid` and `rsp_out_data` hold their last value while `rsp_out_valid` is 0.

Full-FIFO behaviour:
- A push into a full FIFO is dropped and sets `err_overflow`, unless that FIFO pops in the same cycle, in which case the push succeeds.

Age counter (width $clog2(TIMEOUT+1)):
- Counts while the request FIFO is non-empty.
- Returns to 0 on every request-FIFO pop and while the FIFO is empty.
- Saturates at TIMEOUT. `err_timeout` is set on the cycle the counter reaches TIMEOUT.

Counters and errors:
- `rsp_count` increments on each `rsp_out_valid`.
- Sticky errors clear on `err_clr`. If a clear and a new error event coincide, set wins.

## Timing
Reset (`pck_cp2af_softReset_n` = 0 at a clock edge):
- Both FIFOs empty; age counter 0.
- All outputs 0: valid, tid, data, outstanding, rsp_count, and all error flags.
- Inputs are ignored during reset. Reset asserted mid-traffic discards all buffered entries with no output pulse.

Latency:
- `rsp_in_valid` sampled at edge E, response FIFO empty, `c2_hold` low: `rsp_out_valid` is high in the cycle following edge E+1, i.e. 2 cycles.
- With a back-to-back input stream and `c2_hold` low, one response is issued per cycle.

Other rules:
- `outstanding` updates the cycle after a push or pop.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
- `c2_hold` sampled high at edge E blocks the pop at E, so no pulse follows E.

## Test plan
- **Single read:** reset, then `req_tid`=0x05; 3 cycles later `rsp_in` tid 0x05, data 0x0000_0000_DEAD_BEEF → one `rsp_out_valid` pulse with tid 0x05 and that data, 2 cycles after `rsp_in`; `outstanding` returns 0; `rsp_count`=1; no errors.
- **Throttle and fill:** `c2_hold`=1; 8 requests with tids 0..7 and 8 matching responses → nothing issued, FIFO full, no error. A 9th response → `err_overflow`=1. Release `c2_hold` → 8 consecutive pulses with tids 0..7 in order.
- **Mismatch:** request tid 0x10, response tid 0x11 → `err_tid_mismatch`=1; the response is still issued with tid 0x11. A response while nothing is outstanding also sets the flag.
- **Timeout:** one request, no response → `err_timeout` is 0 after 511 cycles and 1 after 512. `err_clr` clears it; it stays clear once the response arrives.
- **Simultaneous and reset:** push and pop with the FIFO full in the same cycle → no overflow. Assert reset mid-burst with 4 responses buffered → no further pulses; all outputs 0; `rsp_count`=0.
